// File: rtl/telem_pkg.sv
// telem_pkg: shared types and constants for the telemetry packet receiver.
//   parse_st_t : packet parser states
//   rx_st_t    : UART byte receiver states
//   HDR0/HDR1  : packet header bytes
package telem_pkg;

    typedef enum logic [1:0] {
        HUNT0,
        HUNT1,
        PAYLOAD
    } parse_st_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_st_t;

    localparam logic [7:0] HDR0 = 8'hAA;
    localparam logic [7:0] HDR1 = 8'h55;

endpackage

// File: rtl/telem_byte_rx.sv
// telem_byte_rx: 8N1 UART byte receiver, LSB first.
//   clk, rst_n : system clock, async active-low reset
//   rx         : raw asynchronous serial line (idle high)
//   byte_rdy   : one-cycle pulse, byte_data valid, stop bit was 1
//   byte_data  : last received byte (stable until the next byte's data phase)
//   frm_err    : one-cycle pulse, stop bit sampled 0, byte discarded
module telem_byte_rx
    import telem_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_rdy,
    output logic [7:0] byte_data,
    output logic       frm_err
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_prev;
    rx_st_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift, shift_d;
    logic          rdy_d, ferr_d;

    assign rx_s      = sync_q[1];
    assign byte_data = shift;

    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        rdy_d     = 1'b0;
        ferr_d    = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                // Midpoint recheck rejects glitches shorter than half a bit.
                if (cnt == HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift[7:1]};
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    rdy_d   = rx_s;
                    ferr_d  = !rx_s;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= 2'b11;
            rx_prev  <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            byte_rdy <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], rx};
            rx_prev  <= rx_s;
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
            byte_rdy <= rdy_d;
            frm_err  <= ferr_d;
        end
    end

endmodule

// File: rtl/telem_pkt_rcv.sv
// telem_pkt_rcv: telemetry packet receiver (AA 55 + 2*NUM_CH payload bytes).
//   clk, rst_n : system clock, async active-low reset
//   RX         : raw UART line, 8N1
//   ch_data    : last good packet, channel k at [k*DATA_W +: DATA_W]
//   pkt_vld    : one-cycle pulse when ch_data updates
//   pkt_cnt    : good packet count (wraps)
//   err_cnt    : framing/header/timeout error count (saturates at 255)
//   err        : one-cycle pulse per error
module telem_pkt_rcv
    import telem_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 12,
    parameter int TMO_BITS = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     RX,
    output logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     pkt_vld,
    output logic [15:0]              pkt_cnt,
    output logic [7:0]               err_cnt,
    output logic                     err
);

    localparam int NB       = 2 * NUM_CH;
    localparam int IW       = $clog2(NB);
    localparam int TMO_CLKS = TMO_BITS * BAUD_DIV;
    localparam int TW       = $clog2(TMO_CLKS + 1);

    logic                     byte_rdy, frm_err;
    logic [7:0]               byte_data;
    parse_st_t                state, state_d;
    logic [IW-1:0]            idx, idx_d;
    logic [TW-1:0]            tmo_cnt;
    logic [NUM_CH*DATA_W-1:0] shadow, shadow_nx;
    logic                     load, hdr_err, tmo_err, err_any;

    telem_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (RX),
        .byte_rdy (byte_rdy),
        .byte_data(byte_data),
        .frm_err  (frm_err)
    );

    always_comb begin
        state_d = state;
        idx_d   = idx;
        load    = 1'b0;
        hdr_err = 1'b0;
        tmo_err = 1'b0;
        if (frm_err) begin
            state_d = HUNT0;
        end else if (byte_rdy) begin
            case (state)
                HUNT0: if (byte_data == HDR0) state_d = HUNT1;
                HUNT1: begin
                    if (byte_data == HDR1) begin
                        state_d = PAYLOAD;
                        idx_d   = '0;
                    end else if (byte_data != HDR0) begin
                        state_d = HUNT0;
                        hdr_err = 1'b1;
                    end
                end
                PAYLOAD: begin
                    idx_d = idx + 1'b1;
                    if (idx == IW'(NB - 1)) begin
                        load    = 1'b1;
                        state_d = HUNT0;
                    end
                end
                default: state_d = HUNT0;
            endcase
        end else if (state != HUNT0 && tmo_cnt == TW'(TMO_CLKS - 1)) begin
            tmo_err = 1'b1;
            state_d = HUNT0;
        end
    end

    // Payload bytes are assembled straight into channel slots; the high byte
    // fills the upper DATA_W-8 bits. ch_data takes the whole shadow at once.
    always_comb begin
        shadow_nx = shadow;
        if (state == PAYLOAD && byte_rdy) begin
            if (!idx[0])
                shadow_nx[int'(idx >> 1) * DATA_W + 8 +: DATA_W - 8] = byte_data[DATA_W-9:0];
            else
                shadow_nx[int'(idx >> 1) * DATA_W +: 8] = byte_data;
        end
    end

    assign err_any = frm_err | hdr_err | tmo_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HUNT0;
            idx     <= '0;
            tmo_cnt <= '0;
            shadow  <= '0;
            ch_data <= '0;
            pkt_vld <= 1'b0;
            pkt_cnt <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            shadow  <= shadow_nx;
            // Timer restarts on every byte and idles while hunting for HDR0.
            tmo_cnt <= (state_d == HUNT0 || byte_rdy) ? '0 : tmo_cnt + 1'b1;
            if (load) ch_data <= shadow_nx;
            pkt_vld <= load;
            if (load) pkt_cnt <= pkt_cnt + 16'd1;
            err     <= err_any;
            if (err_any && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_telem_pkt_rcv.sv
// tb_telem_pkt_rcv: self-checking bench for telem_pkt_rcv with a byte-stream
// reference model (header match, payload collection, error accounting).
module tb_telem_pkt_rcv;

    localparam int BD = 16;
    localparam int NC = 3;
    localparam int DW = 12;
    localparam int TB = 20;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             RX = 1'b1;
    logic [NC*DW-1:0] ch_data;
    logic             pkt_vld;
    logic [15:0]      pkt_cnt;
    logic [7:0]       err_cnt;
    logic             err;

    telem_pkt_rcv #(.BAUD_DIV(BD), .NUM_CH(NC), .DATA_W(DW), .TMO_BITS(TB)) dut (
        .clk(clk), .rst_n(rst_n), .RX(RX), .ch_data(ch_data), .pkt_vld(pkt_vld),
        .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int vld_seen = 0;
    int err_seen = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_vld === 1'b1) vld_seen++;
            if (err === 1'b1) err_seen++;
        end
    end

    // Reference model
    bit               got_aa;
    bit               collecting;
    byte unsigned     pay[$];
    logic [NC*DW-1:0] m_ch;
    int               m_pkts;
    int               m_errs;

    function automatic void model_clear();
        got_aa = 0; collecting = 0; pay.delete();
        m_ch = '0; m_pkts = 0; m_errs = 0;
    endfunction

    function automatic void model_byte(input byte unsigned b);
        if (collecting) begin
            pay.push_back(b);
            if (pay.size() == 2 * NC) begin
                for (int k = 0; k < NC; k++)
                    m_ch[k*DW +: DW] = DW'((int'(pay[2*k]) % (1 << (DW - 8))) * 256 + int'(pay[2*k+1]));
                m_pkts++;
                collecting = 0;
                got_aa = 0;
                pay.delete();
            end
        end else if (got_aa) begin
            if (b == 8'h55) begin collecting = 1; got_aa = 0; end
            else if (b != 8'hAA) begin got_aa = 0; m_errs++; end
        end else begin
            got_aa = (b == 8'hAA);
        end
    endfunction

    function automatic void model_abort();
        m_errs++; got_aa = 0; collecting = 0; pay.delete();
    endfunction

    function automatic int exp_errcnt();
        return (m_errs > 255) ? 255 : m_errs;
    endfunction

    // Serial driver: start, 8 data LSB first, stop, then idle gap
    task automatic send_raw(input logic [7:0] b, input logic stop, input int gap);
        @(negedge clk) RX = 1'b0;
        repeat (BD - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) RX = b[i];
            repeat (BD - 1) @(negedge clk);
        end
        @(negedge clk) RX = stop;
        repeat (BD - 1) @(negedge clk);
        @(negedge clk) RX = 1'b1;
        repeat (gap * BD) @(negedge clk);
    endtask

    task automatic tx(input logic [7:0] b);
        send_raw(b, 1'b1, 1 + $urandom_range(0, 1));
        model_byte(b);
    endtask

    task automatic tx_bad(input logic [7:0] b);
        send_raw(b, 1'b0, 1);
        model_abort();
    endtask

    task automatic tx_rand_pkt();
        tx(8'hAA); tx(8'h55);
        for (int i = 0; i < 2 * NC; i++) tx(8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0; RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        vld_seen = 0; err_seen = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ch_data !== '0) begin errors++; $display("FAIL reset_ch_data got %h exp 0", ch_data); end
        checks++; if (pkt_vld !== 1'b0) begin errors++; $display("FAIL reset_pkt_vld got %b exp 0", pkt_vld); end
        checks++; if (pkt_cnt !== 16'd0) begin errors++; $display("FAIL reset_pkt_cnt got %0d exp 0", pkt_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    endtask

    task automatic test_known_packet();
        logic [7:0] seq[8] = '{8'hAA, 8'h55, 8'h0B, 8'h80, 8'h02, 8'h3C, 8'h07, 8'h00};
        foreach (seq[i]) tx(seq[i]);
        checks++; if (ch_data !== 36'h700_23C_B80) begin errors++; $display("FAIL known_ch_data got %h exp 70023cb80", ch_data); end
        checks++; if (ch_data !== m_ch) begin errors++; $display("FAIL known_model got %h exp %h", ch_data, m_ch); end
        checks++; if (vld_seen != 1) begin errors++; $display("FAIL known_vld_pulses got %0d exp 1", vld_seen); end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL known_pkt_cnt got %0d exp 1", pkt_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL known_err_cnt got %0d exp 0", err_cnt); end
    endtask

    task automatic test_header_resync();
        int e0, v0;
        tx(8'hAA); tx(8'hAA); tx(8'h55);
        for (int i = 0; i < 2 * NC; i++) tx(8'($urandom_range(0, 8'h54)));
        checks++; if (ch_data !== m_ch) begin errors++; $display("FAIL aa_aa_ch_data got %h exp %h", ch_data, m_ch); end
        checks++; if (pkt_cnt !== 16'(m_pkts)) begin errors++; $display("FAIL aa_aa_pkt_cnt got %0d exp %0d", pkt_cnt, m_pkts); end
        e0 = err_seen; v0 = vld_seen;
        checks++; if (err_cnt !== 8'(exp_errcnt())) begin errors++; $display("FAIL aa_aa_err_cnt got %0d exp %0d", err_cnt, exp_errcnt()); end
        tx(8'hAA); tx(8'h13);
        checks++; if (err_seen != e0 + 1) begin errors++; $display("FAIL hdr_err_pulse got %0d exp %0d", err_seen, e0 + 1); end
        checks++; if (err_cnt !== 8'(exp_errcnt())) begin errors++; $display("FAIL hdr_err_cnt got %0d exp %0d", err_cnt, exp_errcnt()); end
        // Back in HUNT0: a stray 55 plus payload must not form a packet.
        tx(8'h55); tx(8'h0B); tx(8'h80); tx(8'h02); tx(8'h3C); tx(8'h07); tx(8'h00);
        checks++; if (vld_seen != v0) begin errors++; $display("FAIL hunt0_no_pkt got %0d exp %0d", vld_seen, v0); end
        checks++; if (err_seen != e0 + 1) begin errors++; $display("FAIL hunt0_no_err got %0d exp %0d", err_seen, e0 + 1); end
    endtask

    task automatic test_framing();
        logic [NC*DW-1:0] held;
        int v0;
        held = ch_data; v0 = vld_seen;
        tx(8'hAA); tx(8'h55); tx(8'h12); tx(8'h34); tx(8'h56);
        tx_bad(8'h78);
        tx(8'h9A); tx(8'hBC);
        checks++; if (err_cnt !== 8'(exp_errcnt())) begin errors++; $display("FAIL frm_err_cnt got %0d exp %0d", err_cnt, exp_errcnt()); end
        checks++; if (vld_seen != v0) begin errors++; $display("FAIL frm_no_vld got %0d exp %0d", vld_seen, v0); end
        checks++; if (ch_data !== held) begin errors++; $display("FAIL frm_ch_held got %h exp %h", ch_data, held); end
        tx_rand_pkt();
        checks++; if (ch_data !== m_ch) begin errors++; $display("FAIL frm_next_pkt got %h exp %h", ch_data, m_ch); end
        checks++; if (vld_seen != v0 + 1) begin errors++; $display("FAIL frm_next_vld got %0d exp %0d", vld_seen, v0 + 1); end
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_seen;
        tx(8'hAA); tx(8'h55); tx(8'h01); tx(8'h02); tx(8'h03);
        repeat (25 * BD) @(negedge clk);
        if (got_aa || collecting) model_abort();
        checks++; if (err_seen != e0 + 1) begin errors++; $display("FAIL tmo_pulse got %0d exp %0d", err_seen, e0 + 1); end
        checks++; if (err_cnt !== 8'(exp_errcnt())) begin errors++; $display("FAIL tmo_err_cnt got %0d exp %0d", err_cnt, exp_errcnt()); end
        tx_rand_pkt();
        checks++; if (ch_data !== m_ch) begin errors++; $display("FAIL tmo_next_pkt got %h exp %h", ch_data, m_ch); end
        checks++; if (pkt_cnt !== 16'(m_pkts)) begin errors++; $display("FAIL tmo_pkt_cnt got %0d exp %0d", pkt_cnt, m_pkts); end
    endtask

    task automatic test_glitch();
        int e0, v0;
        e0 = err_seen; v0 = vld_seen;
        @(negedge clk) RX = 1'b0;
        @(negedge clk) RX = 1'b1;
        repeat (30 * BD) @(negedge clk);
        checks++; if (err_seen != e0) begin errors++; $display("FAIL glitch_err got %0d exp %0d", err_seen, e0); end
        checks++; if (vld_seen != v0) begin errors++; $display("FAIL glitch_vld got %0d exp %0d", vld_seen, v0); end
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) begin
            int ng;
            ng = $urandom_range(0, 2);
            for (int g = 0; g < ng; g++)
                tx(($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom));
            tx_rand_pkt();
            checks++; if (ch_data !== m_ch) begin errors++; $display("FAIL rand_ch_data[%0d] got %h exp %h", p, ch_data, m_ch); end
            checks++; if (pkt_cnt !== 16'(m_pkts)) begin errors++; $display("FAIL rand_pkt_cnt[%0d] got %0d exp %0d", p, pkt_cnt, m_pkts); end
            checks++; if (err_seen != m_errs) begin errors++; $display("FAIL rand_err_pulses[%0d] got %0d exp %0d", p, err_seen, m_errs); end
        end
        checks++; if (vld_seen != m_pkts) begin errors++; $display("FAIL rand_vld_pulses got %0d exp %0d", vld_seen, m_pkts); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) tx_bad(8'($urandom));
        checks++; if (err_cnt !== 8'(exp_errcnt())) begin errors++; $display("FAIL sat_err_cnt got %0d exp %0d", err_cnt, exp_errcnt()); end
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt_255 got %0d exp 255", err_cnt); end
        checks++; if (err_seen != m_errs) begin errors++; $display("FAIL sat_err_pulses got %0d exp %0d", err_seen, m_errs); end
    endtask

    task automatic test_reset_mid();
        tx(8'hAA); tx(8'h55); tx(8'h0F); tx(8'hFF);
        @(negedge clk) RX = 1'b0;
        repeat (3 * BD) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ch_data !== '0) begin errors++; $display("FAIL mid_rst_ch_data got %h exp 0", ch_data); end
        checks++; if (pkt_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_cnts got %0d/%0d exp 0/0", pkt_cnt, err_cnt); end
        checks++; if (pkt_vld !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses got %b/%b exp 0/0", pkt_vld, err); end
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear(); vld_seen = 0; err_seen = 0;
        repeat (3) @(negedge clk);
        tx(8'hAA); tx(8'h55); tx(8'h0B); tx(8'h80); tx(8'h02); tx(8'h3C); tx(8'h07); tx(8'h00);
        checks++; if (ch_data !== 36'h700_23C_B80) begin errors++; $display("FAIL mid_rst_pkt got %h exp 70023cb80", ch_data); end
        checks++; if (pkt_cnt !== 16'd1 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_after got %0d/%0d exp 1/0", pkt_cnt, err_cnt); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_known_packet();
        test_header_resync();
        test_framing();
        test_timeout();
        test_glitch();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
